// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared types and constants for the instruction-fetch front end
package fetch_queue_pkg;

  localparam logic [31:0] NOP_INSTR            = 32'h0000_0000;
  localparam logic [31:0] PC_INCREMENT_DEFAULT = 32'd4;
  localparam int unsigned ENTRY_W              = 64;

  typedef enum logic {
    FS_RUN = 1'b0,
    FS_END = 1'b1
  } fetch_state_e;

  // One buffered fetch: the instruction word and the PC it was read from.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry ring buffer of {instr, pc} with push, pop and flush
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [ENTRY_W-1:0]     push_data,
  output logic [ENTRY_W-1:0]     head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointers wrap for free because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = fetch_entry_t'(push_data);
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign full      = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch PC generation, ROM read and buffered instruction delivery to IF/ID
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter logic [31:0] PC_INCREMENT = PC_INCREMENT_DEFAULT,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned MEMORY_DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [31:0]            imem_addr,
  input  logic [31:0]            imem_data,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  output logic                   out_valid,
  output logic [31:0]            out_instr,
  output logic [31:0]            out_pc_plus_4,
  output logic [$clog2(DEPTH):0] queue_count
);

  localparam logic [31:0] LAST_PC = RESET_PC + 32'(4 * (MEMORY_DEPTH - 1));

  fetch_state_e       state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic               push, pop, full;
  logic [ENTRY_W-1:0] head_data;
  fetch_entry_t       head;
  logic               unused_pc_lsbs;

  assign unused_pc_lsbs = ^redirect_pc[1:0];

  // Redirect outranks everything: no push or pop happens on a flush edge.
  assign out_valid = (queue_count != '0);
  assign pop       = out_valid & ~stall & ~redirect;
  assign push      = (state_q == FS_RUN) & ~redirect & (~full | pop);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      state_d    = FS_RUN;
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + PC_INCREMENT;
      if (fetch_pc_q == LAST_PC) begin
        state_d = FS_END;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= FS_RUN;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .flush     (redirect),
    .push      (push),
    .pop       (pop),
    .push_data ({imem_data, fetch_pc_q}),
    .head_data (head_data),
    .count     (queue_count),
    .full      (full)
  );

  assign head          = fetch_entry_t'(head_data);
  assign imem_addr     = fetch_pc_q;
  assign out_instr     = out_valid ? head.instr : NOP_INSTR;
  assign out_pc_plus_4 = out_valid ? (head.pc + PC_INCREMENT) : 32'h0;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  logic [31:0] a_addr, a_data, a_instr, a_pc4;
  logic        a_valid;
  logic [2:0]  a_count;
  logic [31:0] b_addr, b_data, b_instr, b_pc4;
  logic        b_valid;
  logic [2:0]  b_count;

  logic        mon_sel = 1'b0;
  logic        mon_en  = 1'b0;
  logic        sel_valid;
  logic [31:0] sel_instr, sel_pc4, sel_addr;
  logic [2:0]  sel_count;

  int          checks   = 0;
  int          failures = 0;
  logic [63:0] sb [$];
  logic [63:0] exp_w;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] addr, input int depth);
    logic [29:0] idx;
    idx = addr[31:2];
    if (idx < 30'(depth)) return 32'(idx) + 32'd1;
    return 32'h0;
  endfunction

  assign a_data = rom_word(a_addr, 64);
  assign b_data = rom_word(b_addr, 8);

  fetch_queue u_dut_a (
    .clk(clk), .reset(reset), .imem_addr(a_addr), .imem_data(a_data),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(a_valid), .out_instr(a_instr), .out_pc_plus_4(a_pc4), .queue_count(a_count)
  );

  fetch_queue #(.MEMORY_DEPTH(8)) u_dut_b (
    .clk(clk), .reset(reset), .imem_addr(b_addr), .imem_data(b_data),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(b_valid), .out_instr(b_instr), .out_pc_plus_4(b_pc4), .queue_count(b_count)
  );

  assign sel_valid = mon_sel ? b_valid : a_valid;
  assign sel_instr = mon_sel ? b_instr : a_instr;
  assign sel_pc4   = mon_sel ? b_pc4   : a_pc4;
  assign sel_addr  = mon_sel ? b_addr  : a_addr;
  assign sel_count = mon_sel ? b_count : a_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Word i of the ROM holds i+1 and lives at PC 4*i, so PC+4 is 4*(i+1).
  task automatic expect_word(input int idx);
    sb.push_back({32'(idx + 1), 32'(4 * (idx + 1))});
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (sel_valid) begin
        if (!stall && !redirect) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_underflow actual=%h required=none t=%0t", sel_instr, $time);
          end else begin
            exp_w = sb.pop_front();
            chk("stream_instr", sel_instr, exp_w[63:32]);
            chk("stream_pc4", sel_pc4, exp_w[31:0]);
          end
        end
      end else begin
        chk("bubble_instr", sel_instr, 32'h0);
        chk("bubble_pc4", sel_pc4, 32'h0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic finish_stream();
    tick();
    mon_en = 1'b0;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic apply_reset(input logic st);
    reset = 1'b0;
    stall = st;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    tick();
    chk("rst_valid", 32'(sel_valid), 32'd0);
    chk("rst_instr", sel_instr, 32'h0);
    chk("rst_pc4", sel_pc4, 32'h0);
    chk("rst_count", 32'(sel_count), 32'd0);
    chk("rst_addr", sel_addr, 32'h0);
    tick();
    reset = 1'b1;
  endtask

  task automatic run_stream();
    for (int i = 0; i < 4; i++) expect_word(i);
    mon_en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("s1_count", 32'(sel_count), 32'd1);
      chk("s1_instr", sel_instr, 32'(k));
      chk("s1_pc4", sel_pc4, 32'(4 * k));
    end
    finish_stream();
  endtask

  task automatic after_redirect_0x22();
    tick();
    redirect = 1'b0;
    stall = 1'b0;
    expect_word(8);
    mon_en = 1'b1;
    chk("rd_count", 32'(sel_count), 32'd0);
    chk("rd_valid", 32'(sel_valid), 32'd0);
    chk("rd_instr", sel_instr, 32'h0);
    chk("rd_addr", sel_addr, 32'h20);
    tick();
    chk("rd_first_instr", sel_instr, 32'd9);
    chk("rd_first_pc4", sel_pc4, 32'h24);
    finish_stream();
  endtask

  initial begin
    // Scenario 1: free-running fetch after reset
    apply_reset(1'b0);
    run_stream();

    // Scenario 2: stall fills the queue, then drains without gaps
    for (int i = 0; i < 5; i++) expect_word(i);
    apply_reset(1'b1);
    mon_en = 1'b1;
    repeat (6) tick();
    chk("s2_count_full", 32'(sel_count), 32'd4);
    chk("s2_addr_hold", sel_addr, 32'h10);
    chk("s2_instr_hold", sel_instr, 32'd1);
    stall = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("s2_valid", 32'(sel_valid), 32'd1);
      chk("s2_instr", sel_instr, 32'(k + 1));
      if (k < 4) tick();
    end
    finish_stream();

    // Scenario 3: redirect with three entries queued
    apply_reset(1'b1);
    repeat (3) tick();
    chk("s3_count", 32'(sel_count), 32'd3);
    redirect = 1'b1;
    redirect_pc = 32'h22;
    after_redirect_0x22();

    // Scenario 4: redirect beats stall while full
    apply_reset(1'b1);
    repeat (5) tick();
    chk("s4_count", 32'(sel_count), 32'd4);
    chk("s4_addr", sel_addr, 32'h10);
    redirect = 1'b1;
    redirect_pc = 32'h22;
    after_redirect_0x22();

    // Scenario 5: end of ROM on the 8-word instance, then restart
    mon_sel = 1'b1;
    apply_reset(1'b0);
    for (int i = 0; i < 8; i++) expect_word(i);
    mon_en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("s5_instr", sel_instr, 32'(k));
    end
    chk("s5_addr_end", sel_addr, 32'h20);
    tick();
    chk("s5_drained_valid", 32'(sel_valid), 32'd0);
    chk("s5_drained_count", 32'(sel_count), 32'd0);
    chk("s5_addr_hold", sel_addr, 32'h20);
    tick();
    chk("s5_no_push", 32'(sel_count), 32'd0);
    chk("s5_addr_hold2", sel_addr, 32'h20);
    redirect = 1'b1;
    redirect_pc = 32'h0;
    tick();
    redirect = 1'b0;
    chk("s5_rd_valid", 32'(sel_valid), 32'd0);
    chk("s5_rd_addr", sel_addr, 32'h0);
    expect_word(0);
    tick();
    chk("s5_restart_instr", sel_instr, 32'd1);
    finish_stream();
    mon_sel = 1'b0;

    // Scenario 6: asynchronous reset between edges
    apply_reset(1'b1);
    repeat (2) tick();
    chk("s6_count", 32'(sel_count), 32'd2);
    #2;
    reset = 1'b0;
    #1;
    chk("s6_async_valid", 32'(sel_valid), 32'd0);
    chk("s6_async_instr", sel_instr, 32'h0);
    chk("s6_async_count", 32'(sel_count), 32'd0);
    tick();
    reset = 1'b1;
    stall = 1'b0;
    run_stream();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch front end. Sits directly upstream of the IF/ID pipeline register.
- Generates the fetch PC, reads the combinational program ROM, and buffers fetched words in a small FIFO.
- Presents one instruction plus its PC+4 per cycle to IF/ID. When empty, presents a NOP bubble.
- Accepts stall from the hazard logic. Accepts a redirect (branch/jump/jr target) that flushes the queue.

Parameters:
DEPTH, 4, queue entries; must be a power of two, at least 2.
PC_INCREMENT, 4, byte increment per fetched word.
RESET_PC, 32'h0000_0000, fetch PC after reset.
MEMORY_DEPTH, 64, program ROM size in words; fetching stops past RESET_PC + 4*MEMORY_DEPTH.

Ports:
clk  in  1  single clock, rising edge.
reset  in  1  asynchronous, active-low reset.
imem_addr  out  32  fetch address to ProgramMemory; equals fetch_pc.
imem_data  in  32  instruction at imem_addr, valid in the same cycle.
stall  in  1  downstream is not consuming this cycle.
redirect  in  1  flush and restart fetch at redirect_pc.
redirect_pc  in  32  new fetch address; bits [1:0] are forced to 0.
out_valid  out  1  out_instr/out_pc_plus_4 hold a real instruction.
out_instr  out  32  head instruction; 32'h0000_0000 (NOP) when out_valid=0.
out_pc_plus_4  out  32  head PC + PC_INCREMENT; 0 when out_valid=0.
queue_count  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (asynchronous, reset=0), effective immediately:
  - count=0, rd_ptr=0, wr_ptr=0, fetch_pc=RESET_PC, state=RUN.
  - out_valid=0, out_instr=0, out_pc_plus_4=0, queue_count=0.
- Outputs are driven from the queue head, combinationally from registered storage. No bypass: fetch-to-output latency is 1 clock.
- pop = out_valid & ~stall & ~redirect.
- push = (state==RUN) & ~redirect & (count<DEPTH | pop).
  - A push stores {imem_data, fetch_pc} at wr_ptr, then fetch_pc <= fetch_pc + PC_INCREMENT (32-bit, wraps mod 2^32).
- Simultaneous push and pop: count unchanged, both pointers advance. Pointers wrap modulo DEPTH.
- Full (count==DEPTH) with no pop: no push; fetch_pc and imem_addr hold.
- Empty: out_valid=0 and NOP outputs. A stall while empty has no effect on fetching.
- Redirect has highest priority, including over stall and full. On that clock edge:
  - count, rd_ptr and wr_ptr are cleared; nothing is pushed or popped.
  - fetch_pc <= {redirect_pc[31:2],2'b00}; state <= RUN.
  - Next cycle: out_valid=0, imem_addr = the new PC. The first redirected instruction appears the cycle after.
- FSM, two states:
  - RUN: fetching. Go to END when a push writes the word at RESET_PC + 4*(MEMORY_DEPTH-1).
  - END: no pushes; imem_addr holds the last fetch_pc + PC_INCREMENT; the queue drains normally. Leave END only on redirect (to RUN) or reset.
- Consumed bubbles are NOPs, so IF/ID needs no valid bit.

Decomposition:
- Shared package: NOP_INSTR = 32'h0, fetch-state encoding (RUN, END), PC_INCREMENT default.
- One natural sub-module, fetch_fifo: DEPTH x 64-bit storage, pointers, count, push/pop/flush. The FSM and PC logic stay in fetch_queue.

Test Plan:
1. ROM word i = i+1, stall=0; release reset. After edge 1: out_valid=1, out_instr=1, out_pc_plus_4=4. Then 2/8, 3/12 on successive cycles; queue_count stays 1.
2. stall=1 for 6 cycles after reset release. queue_count reaches 4; imem_addr holds 0x10; out_instr holds 1. Release stall: outputs 1, 2, 3, 4, 5 in consecutive cycles with no gaps.
3. With queue_count=3, pulse redirect, redirect_pc=0x22. Next cycle: queue_count=0, out_valid=0, out_instr=0, imem_addr=0x20. Cycle after: out_instr=9, out_pc_plus_4=0x24.
4. redirect=1 and stall=1 in the same cycle with the queue full: the flush happens; the next cycle matches scenario 3.
5. MEMORY_DEPTH=8, stall=0. After the push of 0x1C: state END, no further pushes; queue drains to out_valid=0. Redirect to 0x0: fetching resumes and out_instr=1 two cycles later.
6. Assert reset mid-stream between clock edges with queue_count=2: out_valid, out_instr and queue_count are 0 before the next edge. After release, the scenario 1 sequence restarts from RESET_PC.
